// File: rtl/i3c_target_sdr_if.sv
// Pad-side and user-side signals of the SDR target.
// master = pad/host side, slave = the target itself.
interface i3c_target_sdr_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       busy;
    logic       start_seen;

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_low, rx_data, rx_valid,
        input  tx_ack, busy, start_seen
    );

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_low, rx_data, rx_valid,
        output tx_ack, busy, start_seen
    );
endinterface

// File: rtl/i3c_target_sdr.sv
// Open-drain SDR target: START/STOP detect, static address match,
// byte write strobe and byte read from a host register.
module i3c_target_sdr #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    i3c_target_sdr_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_ev;
    logic                   stop_ev;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] tx_sh;
    logic [7:0] rx_next;
    logic       rw;
    logic       rd_ok;

    // Idle-high reset value keeps reset from looking like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev <= scl_q;
            sda_prev <= sda_q;
        end
    end

    assign scl_q    = scl_sync[SYNC_STAGES-1];
    assign sda_q    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_q & ~scl_prev;
    assign scl_fall = ~scl_q & scl_prev;
    assign start_ev = scl_q & scl_prev & sda_prev & ~sda_q;
    assign stop_ev  = scl_q & scl_prev & ~sda_prev & sda_q;
    assign rx_next  = {shreg[6:0], sda_q};

    // In the ACK states sda_low doubles as the phase marker:
    // low = waiting to drive ACK, high = ACK clock in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bit_cnt        <= 3'd0;
            shreg          <= 8'h00;
            tx_sh          <= 8'h00;
            rw             <= 1'b0;
            rd_ok          <= 1'b0;
            bus.sda_low    <= 1'b0;
            bus.rx_data    <= 8'h00;
            bus.rx_valid   <= 1'b0;
            bus.tx_ack     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.start_seen <= 1'b0;
        end else begin
            bus.rx_valid   <= 1'b0;
            bus.tx_ack     <= 1'b0;
            bus.start_seen <= 1'b0;
            if (start_ev) begin
                state          <= S_ADDR;
                bit_cnt        <= 3'd0;
                bus.start_seen <= 1'b1;
                bus.sda_low    <= 1'b0;
            end else if (stop_ev) begin
                state       <= S_IDLE;
                bus.busy    <= 1'b0;
                bus.sda_low <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_IGNORE: bus.sda_low <= 1'b0;
                    S_ADDR: if (scl_rise) begin
                        shreg   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw <= sda_q;
                            if (shreg[6:0] == ADDR) begin
                                state    <= S_ADDR_ACK;
                                bus.busy <= 1'b1;
                            end else begin
                                state    <= S_IGNORE;
                                bus.busy <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!bus.sda_low) begin
                            bus.sda_low <= 1'b1;
                        end else if (rw) begin
                            tx_sh       <= bus.tx_data;
                            bus.tx_ack  <= 1'b1;
                            bus.sda_low <= ~bus.tx_data[7];
                            bit_cnt     <= 3'd0;
                            state       <= S_RD_DATA;
                        end else begin
                            bus.sda_low <= 1'b0;
                            bit_cnt     <= 3'd0;
                            state       <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shreg   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.rx_data  <= rx_next;
                            bus.rx_valid <= 1'b1;
                            state        <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: if (scl_fall) begin
                        if (!bus.sda_low) begin
                            bus.sda_low <= 1'b1;
                        end else begin
                            bus.sda_low <= 1'b0;
                            bit_cnt     <= 3'd0;
                            state       <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            bus.sda_low <= 1'b0;
                            bit_cnt     <= 3'd0;
                            rd_ok       <= 1'b0;
                            state       <= S_RD_ACK;
                        end else begin
                            bus.sda_low <= ~tx_sh[6];
                            tx_sh       <= {tx_sh[6:0], 1'b0};
                            bit_cnt     <= bit_cnt + 3'd1;
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_q) begin
                                state    <= S_IGNORE;
                                bus.busy <= 1'b0;
                            end else begin
                                rd_ok <= 1'b1;
                            end
                        end else if (scl_fall && rd_ok) begin
                            tx_sh       <= bus.tx_data;
                            bus.tx_ack  <= 1'b1;
                            bus.sda_low <= ~bus.tx_data[7];
                            bit_cnt     <= 3'd0;
                            state       <= S_RD_DATA;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i3c_target_sdr.sv
// Directed bench: bit-banged controller, strobe scoreboard
// plus inline checks of ACK levels, read bytes and busy.
module tb_i3c_target_sdr;

    localparam int HALF = 10;

    typedef enum logic [1:0] {EV_START, EV_RX, EV_TX} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic scl_r;
    logic ctrl_sda;
    logic sda_line;
    int   n_pass = 0;
    int   n_total = 0;
    int   low_cycles = 0;
    ev_t  exp_q[$];

    i3c_target_sdr_if bus ();

    i3c_target_sdr #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign sda_line  = ctrl_sda & ~bus.sda_low;
    assign bus.sda_i = sda_line;
    assign bus.scl_i = scl_r;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected %s strobe data %h", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            check({"event kind ", e.kind.name()}, {6'd0, k}, {6'd0, e.kind});
            if (k == EV_RX) check("rx_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (bus.sda_low) low_cycles <= low_cycles + 1;
        if (!rst) begin
            if (bus.start_seen) pop_check(EV_START, 8'h00);
            if (bus.rx_valid)   pop_check(EV_RX, bus.rx_data);
            if (bus.tx_ack)     pop_check(EV_TX, 8'h00);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ctrl_sda = b;
        wait_clk(HALF);
        scl_r = 1'b1;
        wait_clk(HALF);
        scl_r = 1'b0;
        wait_clk(2);
    endtask

    task automatic recv_bit(output logic b);
        ctrl_sda = 1'b1;
        wait_clk(HALF);
        scl_r = 1'b1;
        wait_clk(HALF / 2);
        b = sda_line;
        wait_clk(HALF / 2);
        scl_r = 1'b0;
        wait_clk(2);
    endtask

    task automatic do_start();
        ctrl_sda = 1'b1;
        wait_clk(HALF);
        scl_r = 1'b1;
        wait_clk(HALF);
        ctrl_sda = 1'b0;
        wait_clk(HALF);
        scl_r = 1'b0;
        wait_clk(2);
    endtask

    task automatic do_stop();
        ctrl_sda = 1'b0;
        wait_clk(HALF);
        scl_r = 1'b1;
        wait_clk(HALF);
        ctrl_sda = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_lvl,
                              input string name);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        check(name, {7'd0, a}, {7'd0, exp_lvl});
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        send_bit(nack);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sda_low"}, {7'd0, bus.sda_low}, 8'h00);
        check({tag, " rx_data"}, bus.rx_data, 8'h00);
        check({tag, " strobes"},
              {5'd0, bus.rx_valid, bus.tx_ack, bus.start_seen}, 8'h00);
        check({tag, " busy"}, {7'd0, bus.busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] rd;
        int         lc;
        rst = 1'b1;
        scl_r = 1'b1;
        ctrl_sda = 1'b1;
        bus.tx_data = 8'h00;
        wait_clk(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        // Write frame
        push(EV_START, 8'h00);
        do_start();
        write_byte(8'h54, 1'b0, "wr addr ack");
        check("wr busy", {7'd0, bus.busy}, 8'h01);
        push(EV_RX, 8'hA5);
        write_byte(8'hA5, 1'b0, "wr data ack");
        do_stop();
        wait_clk(5);
        check("wr busy after stop", {7'd0, bus.busy}, 8'h00);

        // Read frame, ACK then NACK
        bus.tx_data = 8'h3C;
        push(EV_START, 8'h00);
        push(EV_TX, 8'h00);
        push(EV_TX, 8'h00);
        do_start();
        write_byte(8'h55, 1'b0, "rd addr ack");
        read_byte(rd, 1'b0);
        check("rd byte0", rd, 8'h3C);
        read_byte(rd, 1'b1);
        check("rd byte1", rd, 8'h3C);
        wait_clk(5);
        check("rd busy after nack", {7'd0, bus.busy}, 8'h00);
        check("rd sda_low after nack", {7'd0, bus.sda_low}, 8'h00);
        do_stop();

        // Address mismatch
        push(EV_START, 8'h00);
        lc = low_cycles;
        do_start();
        write_byte(8'h22, 1'b1, "mismatch no ack");
        check("mismatch busy", {7'd0, bus.busy}, 8'h00);
        write_byte(8'h33, 1'b1, "mismatch data no ack");
        check("mismatch sda_low cycles", 8'(low_cycles - lc), 8'h00);
        do_stop();

        // Repeated START: write then read
        push(EV_START, 8'h00);
        do_start();
        write_byte(8'h54, 1'b0, "sr addr w ack");
        push(EV_RX, 8'h11);
        write_byte(8'h11, 1'b0, "sr data ack");
        bus.tx_data = 8'h96;
        push(EV_START, 8'h00);
        push(EV_TX, 8'h00);
        do_start();
        write_byte(8'h55, 1'b0, "sr addr r ack");
        read_byte(rd, 1'b1);
        check("sr rd byte", rd, 8'h96);
        do_stop();

        // Abort after 4 data bits, then a clean write
        push(EV_START, 8'h00);
        do_start();
        write_byte(8'h54, 1'b0, "abort addr ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_stop();
        wait_clk(5);
        check("abort busy", {7'd0, bus.busy}, 8'h00);
        push(EV_START, 8'h00);
        do_start();
        write_byte(8'h54, 1'b0, "post-abort addr ack");
        push(EV_RX, 8'h0F);
        write_byte(8'h0F, 1'b0, "post-abort data ack");
        do_stop();

        // Reset while driving a 0 data bit
        bus.tx_data = 8'h00;
        push(EV_START, 8'h00);
        push(EV_TX, 8'h00);
        do_start();
        write_byte(8'h55, 1'b0, "rst-rd addr ack");
        wait_clk(4);
        check("rst-rd driving", {7'd0, bus.sda_low}, 8'h01);
        rst = 1'b1;
        wait_clk(1);
        check_reset_outputs("mid-read reset");
        rst = 1'b0;
        scl_r = 1'b1;
        wait_clk(HALF);
        push(EV_START, 8'h00);
        do_start();
        write_byte(8'h54, 1'b0, "post-rst addr ack");
        push(EV_RX, 8'h5A);
        write_byte(8'h5A, 1'b0, "post-rst data ack");
        do_stop();
        wait_clk(20);
        check("post-rst busy", {7'd0, bus.busy}, 8'h00);
        check("scoreboard drained", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i3c_target_sdr.md
Name: i3c_target_sdr

Overview:
- Bus-side target (responder) for the open-drain SDA/SCL pair that a controller drives through I3C_IOBUF/IOBUF primitives.
- Detects START, repeated START and STOP, and matches a 7-bit static address. ACKs matching frames.
- Accepts write bytes onto a strobe interface and serves read bytes from a host-supplied register.
- Sits between the pin buffer (its O output, and its I/OE inputs wired for open-drain) and user logic; it never drives SDA high.

Parameters:
- ADDR, 7'h2A, static target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop synchroniser depth on scl_i and sda_i (legal values 2..3).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- scl_i  input  1  raw SCL level from the pad buffer.
- sda_i  input  1  raw SDA level from the pad buffer.
- sda_low  output  1  1 = pull SDA low; 0 = release (wired to buffer OE, with I tied 0).
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-clk strobe; rx_data is valid in that cycle.
- tx_data  input  8  byte returned on the next read byte; sampled at load points.
- tx_ack  output  1  one-clk strobe each time tx_data is loaded into the shifter.
- busy  output  1  high from an address match until STOP or NACK.
- start_seen  output  1  one-clk strobe on every START or repeated START.

Behaviour:
- **Input conditioning**
  - scl_i and sda_i each pass through a SYNC_STAGES synchroniser, then a 1-FF history register.
  - The synchroniser reset value is 1, so reset does not create a false edge.
  - Events are derived from synchronised current/previous values:
    - scl_rise, scl_fall.
    - START: sda falls while scl is high.
    - STOP: sda rises while scl is high.
  - Latency from pad edge to event is SYNC_STAGES+1 clk. The bench keeps SCL high/low phases at least 8 clk.
- **Reset**
  - sda_low=0, rx_data=0, rx_valid=0, tx_ack=0, busy=0, start_seen=0, state=IDLE, bit counter=0.
  - A reset asserted mid-frame releases SDA in the next cycle.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- **Global transitions**
  - START in any state: go to ADDR, clear the bit counter, pulse start_seen, set sda_low=0.
  - STOP in any state: go to IDLE, busy=0, sda_low=0.
  - START and STOP take priority over scl edges that occur in the same cycle.
- **Bit handling**
  - Bits are sampled on scl_rise, MSB first; a 3-bit counter wraps after 8.
  - SDA drive changes only on scl_fall.
- **ADDR**
  - After the 8th sample, the upper 7 bits are compared to ADDR.
  - Match: go to ADDR_ACK; assert sda_low at the next scl_fall; busy=1.
  - Mismatch: go to IGNORE with SDA released.
- **ADDR_ACK**
  - On the scl_fall that ends the ACK clock:
    - R/W=0: release SDA and go to WR_DATA.
    - R/W=1: load tx_data into the shifter, pulse tx_ack, drive bit7 (sda_low = ~bit), go to RD_DATA.
- **WR_DATA**
  - After the 8th sample, in the same cycle: update rx_data, pulse rx_valid.
  - Go to WR_ACK; drive ACK low at the next scl_fall and release at the following scl_fall.
  - Return to WR_DATA; multi-byte writes are unlimited.
- **RD_DATA**
  - Shift out on each scl_fall.
  - After the 8th bit's scl_fall, release SDA and go to RD_ACK.
- **RD_ACK**
  - Sample the controller's ACK on scl_rise.
  - 0 (ACK): at the next scl_fall, reload tx_data, pulse tx_ack, drive bit7, go to RD_DATA.
  - 1 (NACK): go to IGNORE, busy=0.
- **IGNORE:** sda_low=0; wait for START or STOP.
- **Other rules**
  - A STOP or repeated START between bits abandons a partial byte: no rx_valid pulse.
  - sda_low is never 1 outside ADDR_ACK, WR_ACK and RD_DATA.

Test Plan:
- Write frame: START, 0x54 (ADDR=0x2A, W), 0xA5, STOP. Required:
  - sda_low=1 during both ACK clocks.
  - rx_valid pulses once with rx_data=0xA5.
  - busy returns to 0 after STOP.
- Read frame: tx_data=0x3C; START, 0x55, controller ACKs, then NACKs the second byte, STOP. Required:
  - SDA bits read 0x3C then 0x3C.
  - tx_ack pulses twice.
  - IGNORE entered after the NACK; sda_low=0.
- Address mismatch: START, 0x22. Required: no ACK (sda_low stays 0), busy=0, no rx_valid until the next START.
- Repeated START: START, 0x54, 0x11, Sr, 0x55, read one byte, NACK. Required:
  - rx_valid with 0x11.
  - start_seen pulses twice.
  - The read returns the current tx_data.
- Abort: STOP after 4 bits of a write data byte. Required: no rx_valid; state IDLE. A following full write of 0x0F is received correctly.
- Reset mid-read: assert rst while sda_low=1 in RD_DATA. Required: sda_low=0 the next clk, all outputs at reset values, and the next frame decodes normally.
